sram_access_ctrl: RTL and testbench

SRAM_ACCESS_CTRL -- requirements
Module: sram_access_ctrl

---
 rtl/sram_ctrl_pkg.sv | 24 ++
 rtl/sram_lane_decode.sv | 29 ++
 rtl/sram_access_ctrl.sv | 111 +++++++++++
 tb/tb_sram_access_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the asynchronous-SRAM access controller.
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_ERROR
  } state_t;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam int WAIT_MIN = 1;
  localparam int WAIT_MAX = 15;

  // Folds an out-of-range WAIT_CYCLES into what the 4-bit wait counter can express.
  function automatic logic [3:0] clamp_wait(input int w);
    if (w < WAIT_MIN) return 4'(WAIT_MIN);
    if (w > WAIT_MAX) return 4'(WAIT_MAX);
    return 4'(w);
  endfunction

endpackage

// File: rtl/sram_lane_decode.sv
// Byte-lane enable decode and alignment check for one AHB transfer.
module sram_lane_decode
  import sram_ctrl_pkg::*;
(
  input  logic [2:0] size,
  input  logic [1:0] addr_lo,
  output logic [3:0] be,
  output logic       illegal
);

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    be      = 4'h0;
    illegal = 1'b0;
    case (size)
      HSIZE_BYTE: be = 4'b0001 << addr_lo;
      HSIZE_HALF: begin
        be      = addr_lo[1] ? 4'b1100 : 4'b0011;
        illegal = addr_lo[0];
      end
      HSIZE_WORD: begin
        be      = 4'hF;
        illegal = |addr_lo;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/sram_access_ctrl.sv
// AHB-side controller that sequences stalled read/write accesses to an asynchronous SRAM.
module sram_access_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic [31:0]           addr,
  input  logic [31:0]           wdata,
  input  logic [2:0]            size,
  input  logic                  r_prep,
  input  logic                  w_prep,
  input  logic                  ren,
  input  logic                  wen,
  output logic [31:0]           rdata,
  output logic                  slave_wait,
  output logic                  burst_cancel,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [31:0]           sram_wdata,
  input  logic [31:0]           sram_rdata,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n,
  output logic [3:0]            sram_be_n
);

  localparam logic [3:0] WAIT_LIM = clamp_wait(WAIT_CYCLES);

  state_t                state, state_d;
  logic [3:0]            cnt, cnt_d;
  logic [ADDR_WIDTH+1:0] cap_addr;
  logic [2:0]            cap_size;
  logic                  cap_write;
  logic [31:0]           wdata_q;

  logic       capture, access, stalling, final_cyc;
  logic [3:0] cap_be, in_be;
  logic       cap_illegal, in_illegal;
  logic       unused_bits;

  // Captured decode drives the lanes; incoming decode picks ACCESS vs ERROR at the capture edge.
  sram_lane_decode u_cap_decode (
    .size    (cap_size),
    .addr_lo (cap_addr[1:0]),
    .be      (cap_be),
    .illegal (cap_illegal)
  );

  sram_lane_decode u_in_decode (
    .size    (size),
    .addr_lo (addr[1:0]),
    .be      (in_be),
    .illegal (in_illegal)
  );

  assign unused_bits = ^{addr[31:ADDR_WIDTH+2], in_be, cap_illegal};

  assign capture   = (r_prep | w_prep) & ~slave_wait;
  assign access    = (state == ST_ACCESS);
  assign stalling  = access & (cnt < WAIT_LIM);
  assign final_cyc = access & ~stalling;

  // State moves at the capture edge so ACCESS/ERROR line up with the ren/wen data phase.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      ST_IDLE:   if (capture) state_d = in_illegal ? ST_ERROR : ST_ACCESS;
      ST_ACCESS: if (final_cyc) state_d = capture ? (in_illegal ? ST_ERROR : ST_ACCESS) : ST_IDLE;
      ST_ERROR:  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (state_d != ST_ACCESS || !access || final_cyc) cnt_d = 4'd0;
    else if (ren | wen)                               cnt_d = cnt + 4'd1;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      cap_addr  <= '0;
      cap_size  <= 3'd0;
      cap_write <= 1'b0;
      wdata_q   <= 32'd0;
    end else begin
      // NOTE: non-blocking so every register samples the values from before this edge.
      state   <= state_d;
      cnt     <= cnt_d;
      wdata_q <= sram_wdata;
      if (capture) begin
        cap_addr  <= addr[ADDR_WIDTH+1:0];
        cap_size  <= size;
        cap_write <= w_prep;
      end
    end
  end

  // Strobes decode straight from state so an asynchronous reset releases them at once.
  assign slave_wait   = stalling;
  assign burst_cancel = (state == ST_ERROR);
  assign sram_addr    = cap_addr[ADDR_WIDTH+1:2];
  assign sram_ce_n    = ~access;
  assign sram_be_n    = access ? ~cap_be : 4'hF;
  assign sram_oe_n    = ~(access & ~cap_write);
  assign sram_we_n    = ~(stalling & cap_write);
  assign sram_wdata   = (access & cap_write) ? wdata : wdata_q;
  assign rdata        = sram_rdata;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Directed bench for sram_access_ctrl: vector table plus back-to-back, stall and reset sequences.
module tb_sram_access_ctrl;

  localparam int W = 2;

  logic        HCLK, HRESETn;
  logic [31:0] addr, wdata, rdata, sram_wdata, sram_rdata;
  logic [2:0]  size;
  logic        r_prep, w_prep, ren, wen;
  logic        slave_wait, burst_cancel;
  logic [15:0] sram_addr;
  logic        sram_ce_n, sram_oe_n, sram_we_n;
  logic [3:0]  sram_be_n;

  int n_cmp = 0;
  int n_err = 0;

  sram_access_ctrl #(.ADDR_WIDTH(16), .WAIT_CYCLES(W)) dut (
    .HCLK         (HCLK),
    .HRESETn      (HRESETn),
    .addr         (addr),
    .wdata        (wdata),
    .size         (size),
    .r_prep       (r_prep),
    .w_prep       (w_prep),
    .ren          (ren),
    .wen          (wen),
    .rdata        (rdata),
    .slave_wait   (slave_wait),
    .burst_cancel (burst_cancel),
    .sram_addr    (sram_addr),
    .sram_wdata   (sram_wdata),
    .sram_rdata   (sram_rdata),
    .sram_ce_n    (sram_ce_n),
    .sram_oe_n    (sram_oe_n),
    .sram_we_n    (sram_we_n),
    .sram_be_n    (sram_be_n)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] data;
    logic        illegal;
    logic [3:0]  be_n;
    logic [15:0] saddr;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 3 units later.
  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " ce_n"}, 32'(sram_ce_n), 32'd1);
    check({tag, " oe_n"}, 32'(sram_oe_n), 32'd1);
    check({tag, " we_n"}, 32'(sram_we_n), 32'd1);
    check({tag, " be_n"}, 32'(sram_be_n), 32'hF);
    check({tag, " wait"}, 32'(slave_wait), 32'd0);
  endtask

  task automatic check_access(input string tag, input logic wr, input int k,
                              input logic [3:0] be_n, input logic [15:0] saddr);
    check({tag, " ce_n"}, 32'(sram_ce_n), 32'd0);
    check({tag, " be_n"}, 32'(sram_be_n), 32'(be_n));
    check({tag, " saddr"}, 32'(sram_addr), 32'(saddr));
    check({tag, " wait"}, 32'(slave_wait), (k < W) ? 32'd1 : 32'd0);
    check({tag, " oe_n"}, 32'(sram_oe_n), wr ? 32'd1 : 32'd0);
    check({tag, " we_n"}, 32'(sram_we_n), (wr && k < W) ? 32'd0 : 32'd1);
    check({tag, " cancel"}, 32'(burst_cancel), 32'd0);
  endtask

  task automatic do_xfer(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("v%0d", idx);
    r_prep = ~v.write;
    w_prep = v.write;
    addr   = v.addr;
    size   = v.size;
    settle();
    check({tag, " addr-phase wait"}, 32'(slave_wait), 32'd0);
    step();
    r_prep = 1'b0;
    w_prep = 1'b0;
    addr   = 32'hFFFF_FFFF;
    ren    = ~v.write;
    wen    = v.write;
    wdata  = v.write ? v.data : 32'h0;
    sram_rdata = v.write ? 32'h0 : v.data;
    if (v.illegal) begin
      settle();
      check({tag, " err cancel"}, 32'(burst_cancel), 32'd1);
      check_idle({tag, " err"});
      step();
      ren = 1'b0;
      wen = 1'b0;
      settle();
      check({tag, " cancel 1-cycle"}, 32'(burst_cancel), 32'd0);
      check_idle({tag, " post-err"});
    end else begin
      for (int k = 0; k <= W; k++) begin
        settle();
        check_access($sformatf("%s k%0d", tag, k), v.write, k, v.be_n, v.saddr);
        if (k == W) begin
          if (v.write) check({tag, " sram_wdata"}, sram_wdata, v.data);
          else         check({tag, " rdata"}, rdata, v.data);
        end
        step();
      end
      ren   = 1'b0;
      wen   = 1'b0;
      wdata = 32'h0;
      settle();
      check_idle({tag, " after"});
      if (v.write) check({tag, " wdata hold"}, sram_wdata, v.data);
    end
    step();
  endtask

  initial begin
    //           write addr          size  data           ill   be_n   saddr
    vecs[0] = '{1'b1, 32'h0000_0010, 3'd2, 32'hDEADBEEF, 1'b0, 4'h0, 16'h0004};
    vecs[1] = '{1'b0, 32'h0000_0013, 3'd0, 32'hAABBCCDD, 1'b0, 4'h7, 16'h0004};
    vecs[2] = '{1'b0, 32'h0000_0001, 3'd1, 32'h0,        1'b1, 4'hF, 16'h0000};
    vecs[3] = '{1'b0, 32'h0000_0022, 3'd1, 32'h11223344, 1'b0, 4'h3, 16'h0008};
    vecs[4] = '{1'b1, 32'h0000_0005, 3'd0, 32'h000000A5, 1'b0, 4'hD, 16'h0001};
    vecs[5] = '{1'b1, 32'h0000_0040, 3'd1, 32'h0000BEEF, 1'b0, 4'hC, 16'h0010};
    vecs[6] = '{1'b1, 32'h0000_0002, 3'd2, 32'h0,        1'b1, 4'hF, 16'h0000};
    vecs[7] = '{1'b0, 32'h0000_0000, 3'd3, 32'h0,        1'b1, 4'hF, 16'h0000};
    vecs[8] = '{1'b0, 32'h0004_0008, 3'd2, 32'hCAFEF00D, 1'b0, 4'h0, 16'h0002};
    vecs[9] = '{1'b0, 32'h0000_0000, 3'd0, 32'h5A5A5A5A, 1'b0, 4'hE, 16'h0000};

    HRESETn = 1'b0;
    addr = 32'h0; wdata = 32'h0; size = 3'd0; sram_rdata = 32'h0;
    r_prep = 1'b0; w_prep = 1'b0; ren = 1'b0; wen = 1'b0;
    #12;
    check_idle("reset");
    check("reset cancel", 32'(burst_cancel), 32'd0);
    check("reset saddr", 32'(sram_addr), 32'd0);
    check("reset sram_wdata", sram_wdata, 32'd0);
    step();
    HRESETn = 1'b1;
    step();

    foreach (vecs[i]) do_xfer(i, vecs[i]);

    // Back-to-back: write 0x20, read 0x24 captured in the write's final cycle.
    w_prep = 1'b1; addr = 32'h20; size = 3'd2;
    step();
    w_prep = 1'b0; wen = 1'b1; wdata = 32'h12345678;
    for (int k = 0; k <= W; k++) begin
      if (k == W) begin
        r_prep = 1'b1; addr = 32'h24; size = 3'd2;
      end
      settle();
      check_access($sformatf("b2b wr k%0d", k), 1'b1, k, 4'h0, 16'h0008);
      step();
    end
    r_prep = 1'b0; wen = 1'b0; ren = 1'b1; wdata = 32'h0; sram_rdata = 32'h0BADF00D;
    for (int k = 0; k <= W; k++) begin
      settle();
      check_access($sformatf("b2b rd k%0d", k), 1'b0, k, 4'h0, 16'h0009);
      if (k == W) check("b2b rdata", rdata, 32'h0BADF00D);
      step();
    end
    ren = 1'b0;
    settle();
    check_idle("b2b after");
    step();

    // ren drops mid-access: counter and slave_wait hold.
    r_prep = 1'b1; addr = 32'h30; size = 3'd2;
    step();
    r_prep = 1'b0; ren = 1'b1;
    settle();
    check("drop c0 wait", 32'(slave_wait), 32'd1);
    step();
    ren = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      check($sformatf("drop hold%0d wait", k), 32'(slave_wait), 32'd1);
      check($sformatf("drop hold%0d ce_n", k), 32'(sram_ce_n), 32'd0);
      step();
    end
    ren = 1'b1;
    settle();
    check("drop resume wait", 32'(slave_wait), 32'd1);
    step();
    settle();
    check("drop final wait", 32'(slave_wait), 32'd0);
    check("drop final ce_n", 32'(sram_ce_n), 32'd0);
    step();
    ren = 1'b0;
    settle();
    check_idle("drop after");
    step();

    // Reset in access cycle 1 of a write: strobes release asynchronously.
    w_prep = 1'b1; addr = 32'h50; size = 3'd2;
    step();
    w_prep = 1'b0; wen = 1'b1; wdata = 32'h77777777;
    step();
    settle();
    check("rst k1 we_n", 32'(sram_we_n), 32'd0);
    HRESETn = 1'b0;
    #1;
    check_idle("rst async");
    check("rst saddr", 32'(sram_addr), 32'd0);
    step();
    HRESETn = 1'b1;
    settle();
    check_idle("rst release");
    step();
    settle();
    check_idle("rst idle wen-high");
    step();
    wen = 1'b0;
    do_xfer(100, vecs[1]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
